// File: rtl/ps2_kbd_rx.sv
// ps2_kbd_rx: receive-only PS/2 keyboard host interface for the 6502 bus.
// Conditions the raw PS/2 pads, deserialises 11-bit device-to-host frames,
// buffers good scan codes in a small FIFO and exposes them via four
// registers. Holds the PS/2 clock low while the FIFO cannot take more data.
`timescale 1ns/1ps
module ps2_kbd_rx #(
   parameter int FILT_LEN = 4,      // samples needed to change a filtered level
   parameter int TIMEOUT  = 16000,  // clk cycles between falls before abort
   parameter int FIFO_AW  = 3       // FIFO address width
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       ps2_clk_i,
   input  logic       ps2_dat_i,
   output logic       ps2_clk_oe,
   input  logic       cs,
   input  logic       we,
   input  logic [1:0] addr,
   input  logic [7:0] din,
   output logic [7:0] dout,
   output logic       irq
);

   localparam int DEPTH = 2 ** FIFO_AW;
   localparam int CW    = FIFO_AW + 1;
   localparam int FW    = $clog2(FILT_LEN + 1);
   localparam int TW    = $clog2(TIMEOUT + 1);

   // Frame receiver states
   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_DATA   = 2'd1;
   localparam logic [1:0] S_PARITY = 2'd2;
   localparam logic [1:0] S_STOP   = 2'd3;

   // Register map
   localparam logic [1:0] A_DATA   = 2'd0;
   localparam logic [1:0] A_STATUS = 2'd1;
   localparam logic [1:0] A_CTRL   = 2'd2;
   localparam logic [1:0] A_COUNT  = 2'd3;

   // ------------------------------------------------------------------
   // Input conditioning
   // ------------------------------------------------------------------
   logic [1:0]    clk_sync, dat_sync;
   logic [FW-1:0] clk_fcnt, dat_fcnt;
   logic          clk_filt, dat_filt;
   logic          clk_filt_d;
   logic          fall;

   // Two-flop synchronisers bring the asynchronous pads into the clk domain.
   // NOTE: non-blocking assignments make each stage capture the value the
   // previous stage held before the edge, which is what builds the chain.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         clk_sync <= 2'b00;
         dat_sync <= 2'b00;
      end else begin
         clk_sync <= {clk_sync[0], ps2_clk_i};
         dat_sync <= {dat_sync[0], ps2_dat_i};
      end
   end

   // Clock-line deglitch: the level follows only after FILT_LEN disagreeing samples in a row.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         clk_fcnt <= '0;
         clk_filt <= 1'b1;
      end else if (clk_sync[1] == clk_filt) begin
         clk_fcnt <= '0;
      end else if (clk_fcnt == FW'(FILT_LEN - 1)) begin
         clk_fcnt <= '0;
         clk_filt <= clk_sync[1];
      end else begin
         clk_fcnt <= clk_fcnt + FW'(1);
      end
   end

   // Data-line deglitch, same rule as the clock line so both see equal delay.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         dat_fcnt <= '0;
         dat_filt <= 1'b1;
      end else if (dat_sync[1] == dat_filt) begin
         dat_fcnt <= '0;
      end else if (dat_fcnt == FW'(FILT_LEN - 1)) begin
         dat_fcnt <= '0;
         dat_filt <= dat_sync[1];
      end else begin
         dat_fcnt <= dat_fcnt + FW'(1);
      end
   end

   // Delayed copy of the filtered clock, used to detect its falling edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) clk_filt_d <= 1'b1;
      else          clk_filt_d <= clk_filt;
   end

   assign fall = clk_filt_d & ~clk_filt;

   // ------------------------------------------------------------------
   // Frame receiver
   // ------------------------------------------------------------------
   logic [1:0]    state;
   logic [2:0]    bit_cnt;
   logic [7:0]    shreg;
   logic          par_bit;
   logic [TW-1:0] tmo_cnt;

   logic in_stop, frame_ok, par_bad_ev, stop_bad_ev, start_bad_ev, timeout_ev;
   logic frame_err_ev;

   // Frame outcome is decided on the stop-bit fall; odd parity covers data plus parity bit.
   assign in_stop      = fall & (state == S_STOP);
   assign frame_ok     = in_stop &  dat_filt &  (^{shreg, par_bit});
   assign par_bad_ev   = in_stop &  dat_filt & ~(^{shreg, par_bit});
   assign stop_bad_ev  = in_stop & ~dat_filt;
   assign start_bad_ev = fall & (state == S_IDLE) & dat_filt;
   // A fall in the same cycle restarts the gap, so it pre-empts the abort.
   assign timeout_ev   = (state != S_IDLE) & ~fall & (tmo_cnt == TW'(TIMEOUT - 1));
   assign frame_err_ev = start_bad_ev | stop_bad_ev | timeout_ev;

   // Inter-edge watchdog: idle frames hold it at zero, every fall restarts it.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                                tmo_cnt <= '0;
      else if ((state == S_IDLE) || fall || timeout_ev) tmo_cnt <= '0;
      else                                         tmo_cnt <= tmo_cnt + TW'(1);
   end

   // Frame FSM: advances one bit per filtered falling edge, LSB first.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= S_IDLE;
         bit_cnt <= '0;
         shreg   <= '0;
         par_bit <= 1'b0;
      end else if (timeout_ev) begin
         state   <= S_IDLE;
         bit_cnt <= '0;
         shreg   <= '0;
      end else if (fall) begin
         case (state)
            S_IDLE: begin
               if (!dat_filt) begin
                  state   <= S_DATA;
                  bit_cnt <= '0;
               end
            end
            S_DATA: begin
               shreg   <= {dat_filt, shreg[7:1]};
               bit_cnt <= bit_cnt + 3'd1;
               if (bit_cnt == 3'd7) state <= S_PARITY;
            end
            S_PARITY: begin
               par_bit <= dat_filt;
               state   <= S_STOP;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Scan-code FIFO
   // ------------------------------------------------------------------
   logic [7:0]         mem [DEPTH];
   logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0]      count;
   logic               empty, full;
   logic               rd_stb, wr_stb, pop, push, ovf_ev;

   assign empty  = (count == '0);
   assign full   = (count == CW'(DEPTH));
   assign rd_stb = cs & ~we;
   assign wr_stb = cs &  we;
   assign pop    = rd_stb & (addr == A_DATA) & ~empty;
   // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte.
   assign push   = frame_ok & (~full | pop);
   assign ovf_ev = frame_ok & full & ~pop;

   // Storage, pointers and occupancy; pointers wrap naturally at DEPTH.
   // NOTE: the array is small enough that clearing it on reset is cheap, and
   // it keeps every flop in the block at a known value after reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= shreg;
            wr_ptr      <= wr_ptr + FIFO_AW'(1);
         end
         if (pop) rd_ptr <= rd_ptr + FIFO_AW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Status flags, control and register reads
   // ------------------------------------------------------------------
   logic       overflow, parity_err, frame_err, irq_en;
   logic [7:0] clr_mask;
   logic [7:0] status;
   logic       unused_din;

   assign clr_mask   = (wr_stb && (addr == A_STATUS)) ? din : 8'h00;
   assign status     = {3'b000, frame_err, parity_err, overflow, full, ~empty};
   assign unused_din = ^{din[7:5], din[1]};

   // Sticky error flags: write-one-to-clear, with a same-cycle set taking priority.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         overflow   <= 1'b0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         overflow   <= (overflow   & ~clr_mask[2]) | ovf_ev;
         parity_err <= (parity_err & ~clr_mask[3]) | par_bad_ev;
         frame_err  <= (frame_err  & ~clr_mask[4]) | frame_err_ev;
      end
   end

   // Control register: interrupt enable only.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                        irq_en <= 1'b0;
      else if (wr_stb && (addr == A_CTRL)) irq_en <= din[0];
   end

   // Registered read port; dout keeps the last value read between accesses.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         dout <= 8'h00;
      end else if (rd_stb) begin
         case (addr)
            A_DATA:   dout <= empty ? 8'h00 : mem[rd_ptr];
            A_STATUS: dout <= status;
            A_CTRL:   dout <= {7'b0000000, irq_en};
            A_COUNT:  dout <= 8'(count);
            default:  dout <= 8'h00;
         endcase
      end
   end

   // Interrupt follows "data waiting and enabled" one cycle later.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) irq <= 1'b0;
      else          irq <= irq_en & ~empty;
   end

   // Inhibit the keyboard only between frames and only while no slot is free.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) ps2_clk_oe <= 1'b0;
      else          ps2_clk_oe <= full & (state == S_IDLE);
   end

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Self-checking bench for ps2_kbd_rx: directed scenarios followed by a
// randomised phase checked against a queue-based model of the receiver.
`timescale 1ns/1ps
module tb_ps2_kbd_rx;

   localparam int DEPTH = 8;
   localparam int SLOW  = 640;   // half bit period for 12.5 kHz at 16 MHz
   localparam int FAST  = 50;    // quicker half period to keep run time short

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       ps2_clk_i = 1'b1;
   logic       ps2_dat_i = 1'b1;
   logic       ps2_clk_oe;
   logic       cs = 1'b0;
   logic       we = 1'b0;
   logic [1:0] addr = 2'd0;
   logic [7:0] din = 8'h00;
   logic [7:0] dout;
   logic       irq;

   int tests = 0;
   int fails = 0;

   // Reference model state
   byte unsigned q[$];
   bit m_ovf, m_perr, m_ferr;

   ps2_kbd_rx dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .ps2_clk_i  (ps2_clk_i),
      .ps2_dat_i  (ps2_dat_i),
      .ps2_clk_oe (ps2_clk_oe),
      .cs         (cs),
      .we         (we),
      .addr       (addr),
      .din        (din),
      .dout       (dout),
      .irq        (irq)
   );

   always #31.25 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp);
      end
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
      @(negedge clk);
      cs = 1'b1; we = 1'b1; addr = a; din = d;
      @(negedge clk);
      cs = 1'b0; we = 1'b0; din = 8'h00;
   endtask

   task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
      @(negedge clk);
      cs = 1'b1; we = 1'b0; addr = a;
      @(negedge clk);
      cs = 1'b0;
      d = dout;
   endtask

   // One PS/2 bit: data set while clock high, then a low half period.
   // Optional glitches: clock pulled low (hi_g cycles) in the high phase,
   // released high (lo_g cycles) in the low phase.
   task automatic send_bit(input logic b, input int half, input int hi_g, input int lo_g);
      ps2_dat_i = b;
      if (hi_g > 0) begin
         wait_cycles(10); ps2_clk_i = 1'b0;
         wait_cycles(hi_g); ps2_clk_i = 1'b1;
         wait_cycles(half - 10 - hi_g);
      end else begin
         wait_cycles(half);
      end
      ps2_clk_i = 1'b0;
      if (lo_g > 0) begin
         wait_cycles(10); ps2_clk_i = 1'b1;
         wait_cycles(lo_g); ps2_clk_i = 1'b0;
         wait_cycles(half - 10 - lo_g);
      end else begin
         wait_cycles(half);
      end
      ps2_clk_i = 1'b1;
   endtask

   // Full 11-bit frame; parity is odd over data+parity unless par_flip.
   task automatic send_frame(input logic [7:0] b, input logic par_flip, input logic stop,
                             input int half, input int gbit, input int hi_g, input int lo_g);
      logic [10:0] bits;
      bits = {stop, (~^b) ^ par_flip, b, 1'b0};
      for (int i = 0; i < 11; i++)
         send_bit(bits[i], half, (i == gbit) ? hi_g : 0, (i == gbit) ? lo_g : 0);
      ps2_dat_i = 1'b1;
      wait_cycles(half);
   endtask

   function automatic logic [7:0] m_status();
      return {3'b000, m_ferr, m_perr, m_ovf, q.size() == DEPTH, q.size() != 0};
   endfunction

   function automatic void m_push(input byte unsigned b);
      if (q.size() < DEPTH) q.push_back(b);
      else                  m_ovf = 1'b1;
   endfunction

   function automatic logic [7:0] m_pop();
      if (q.size() == 0) return 8'h00;
      return q.pop_front();
   endfunction

   initial begin
      logic [7:0] rd;
      int         k;

      // ---- Reset state ----
      wait_cycles(5);
      #1;
      check("rst_dout", dout, 8'h00);
      check("rst_irq", {7'd0, irq}, 8'h00);
      check("rst_oe", {7'd0, ps2_clk_oe}, 8'h00);
      @(negedge clk);
      reset_n = 1'b1;
      wait_cycles(20);
      bus_read(2'd1, rd); check("rst_status", rd, 8'h00);
      bus_read(2'd3, rd); check("rst_count", rd, 8'h00);
      check("idle_oe", {7'd0, ps2_clk_oe}, 8'h00);

      // ---- Valid 0x1C frame at 12.5 kHz with interrupts enabled ----
      bus_write(2'd2, 8'h01);
      bus_read(2'd2, rd); check("ctrl_rd", rd, 8'h01);
      send_frame(8'h1C, 1'b0, 1'b1, SLOW, -1, 0, 0);
      wait_cycles(5);
      bus_read(2'd1, rd); check("f1c_status", rd, 8'h01);
      check("f1c_irq", {7'd0, irq}, 8'h01);
      bus_read(2'd0, rd); check("f1c_data", rd, 8'h1C);
      k = 0;
      while (irq && k < 2) begin @(negedge clk); k++; end
      check("f1c_irq_clear", {7'd0, irq}, 8'h00);
      bus_read(2'd1, rd); check("f1c_status_after", rd, 8'h00);
      bus_read(2'd0, rd); check("empty_read", rd, 8'h00);

      // ---- Parity error ----
      send_frame(8'h1C, 1'b1, 1'b1, FAST, -1, 0, 0);
      wait_cycles(5);
      bus_read(2'd1, rd); check("par_status", rd, 8'h08);
      bus_read(2'd3, rd); check("par_count", rd, 8'h00);
      bus_write(2'd1, 8'h08);
      bus_read(2'd1, rd); check("par_cleared", rd, 8'h00);

      // ---- Fill to full, inhibit, forced overflow ----
      for (int i = 1; i <= 8; i++) send_frame(8'(i), 1'b0, 1'b1, FAST, -1, 0, 0);
      k = 0;
      while (!ps2_clk_oe && k < 20) begin @(negedge clk); k++; end
      check("full_oe", {7'd0, ps2_clk_oe}, 8'h01);
      bus_read(2'd1, rd); check("full_status", rd, 8'h03);
      bus_read(2'd3, rd); check("full_count", rd, 8'h08);
      send_frame(8'h09, 1'b0, 1'b1, FAST, -1, 0, 0);
      wait_cycles(5);
      bus_read(2'd1, rd); check("ovf_status", rd, 8'h07);
      check("ovf_oe", {7'd0, ps2_clk_oe}, 8'h01);
      bus_read(2'd0, rd); check("drain_1", rd, 8'h01);
      @(negedge clk);
      check("oe_release", {7'd0, ps2_clk_oe}, 8'h00);
      for (int i = 2; i <= 8; i++) begin
         bus_read(2'd0, rd); check($sformatf("drain_%0d", i), rd, 8'(i));
      end
      bus_read(2'd1, rd); check("drain_status", rd, 8'h04);
      bus_write(2'd1, 8'h04);
      bus_read(2'd1, rd); check("ovf_cleared", rd, 8'h00);

      // ---- Clock glitches mid-frame ----
      send_frame(8'h5A, 1'b0, 1'b1, FAST, 4, 1, 3);
      send_frame(8'hC3, 1'b0, 1'b1, FAST, 7, 3, 1);
      wait_cycles(5);
      bus_read(2'd3, rd); check("glitch_count", rd, 8'h02);
      bus_read(2'd0, rd); check("glitch_data_a", rd, 8'h5A);
      bus_read(2'd0, rd); check("glitch_data_b", rd, 8'hC3);
      bus_read(2'd1, rd); check("glitch_status", rd, 8'h00);

      // ---- Timeout abort ----
      send_frame(8'h33, 1'b0, 1'b1, FAST, -1, 0, 0);
      send_bit(1'b0, FAST, 0, 0);
      for (int i = 0; i < 4; i++) send_bit(i[0], FAST, 0, 0);
      wait_cycles(16100);
      ps2_dat_i = 1'b1;
      wait_cycles(10);
      bus_read(2'd1, rd); check("tmo_status", rd, 8'h11);
      bus_read(2'd3, rd); check("tmo_count", rd, 8'h01);
      bus_write(2'd1, 8'h10);
      send_frame(8'hF0, 1'b0, 1'b1, FAST, -1, 0, 0);
      wait_cycles(5);
      bus_read(2'd0, rd); check("tmo_keep", rd, 8'h33);
      bus_read(2'd0, rd); check("post_tmo_f0", rd, 8'hF0);
      bus_read(2'd1, rd); check("post_tmo_status", rd, 8'h00);

      // ---- Reset mid-frame ----
      send_frame(8'h77, 1'b0, 1'b1, FAST, -1, 0, 0);
      wait_cycles(5);
      bus_read(2'd3, rd); check("pre_rst_count", rd, 8'h01);
      check("pre_rst_irq", {7'd0, irq}, 8'h01);
      send_bit(1'b0, FAST, 0, 0);
      for (int i = 0; i < 4; i++) send_bit(1'b1, FAST, 0, 0);
      ps2_clk_i = 1'b0;
      wait_cycles(3);
      #7 reset_n = 1'b0;
      #1;
      check("mid_rst_dout", dout, 8'h00);
      check("mid_rst_irq", {7'd0, irq}, 8'h00);
      check("mid_rst_oe", {7'd0, ps2_clk_oe}, 8'h00);
      @(negedge clk);
      ps2_clk_i = 1'b1;
      ps2_dat_i = 1'b1;
      wait_cycles(5);
      reset_n = 1'b1;
      wait_cycles(20);
      bus_read(2'd1, rd); check("mid_rst_status", rd, 8'h00);
      bus_read(2'd3, rd); check("mid_rst_count", rd, 8'h00);
      bus_read(2'd2, rd); check("mid_rst_ctrl", rd, 8'h00);

      // ---- Randomised traffic against the model ----
      q.delete();
      m_ovf = 1'b0; m_perr = 1'b0; m_ferr = 1'b0;
      bus_write(2'd2, 8'h01);
      for (int it = 0; it < 14; it++) begin
         int         kind;
         int         nrd;
         logic [7:0] b;
         kind = int'($urandom_range(0, 3));
         b    = 8'($urandom);
         send_frame(b, kind == 2, kind != 3, FAST, -1, 0, 0);
         case (kind)
            2:       m_perr = 1'b1;
            3:       m_ferr = 1'b1;
            default: m_push(b);
         endcase
         wait_cycles(5);
         check($sformatf("rnd%0d_irq", it), {7'd0, irq}, {7'd0, q.size() != 0});
         nrd = int'($urandom_range(0, 2));
         for (int r = 0; r < nrd; r++) begin
            logic [7:0] exp;
            exp = m_pop();
            bus_read(2'd0, rd); check($sformatf("rnd%0d_data%0d", it, r), rd, exp);
         end
         wait_cycles(2);
         bus_read(2'd1, rd); check($sformatf("rnd%0d_status", it), rd, m_status());
         bus_read(2'd3, rd); check($sformatf("rnd%0d_count", it), rd, 8'(q.size()));
         if ($urandom_range(0, 1) == 1) begin
            bus_write(2'd1, 8'h1C);
            m_ovf = 1'b0; m_perr = 1'b0; m_ferr = 1'b0;
         end
      end
      while (q.size() != 0) begin
         logic [7:0] exp;
         exp = m_pop();
         bus_read(2'd0, rd); check("rnd_drain", rd, exp);
      end
      bus_read(2'd3, rd); check("rnd_final_count", rd, 8'h00);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
